// File: rtl/cache_wb.sv
// Direct-mapped write-back cache, one 128-bit block per line, with a single memory port.
// Define CACHE_WB_COMBINED_ACCESS_EN to merge write-back and refill of a dirty miss into one transaction.
module cache_wb #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic         main_mem_ready,
    input  logic [31:0]  data_address,
    input  logic [31:0]  write_data,
    input  logic [127:0] load_block,
    output logic [31:0]  load_address,
    output logic [31:0]  read_data,
    output logic [127:0] evicted_block,
    output logic [31:0]  evicted_address,
    output logic         evict,
    output logic         load,
    output logic         memoryReady,
    output logic         wait_access
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        WB_LOW,
        WB_HIGH,
        FILL_LOW,
        FILL_HIGH
    } state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tags   [NUM_LINES];
    logic [127:0]         blocks [NUM_LINES];

    logic [1:0]       word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      line_addr;
    logic [31:0]      cur_word;
    logic             request;
    logic             hit;
    logic             write_hit;
    logic             line_done;

    assign word_sel  = data_address[3:2];
    assign idx       = data_address[4 +: IDX_W];
    assign tag       = data_address[31 -: TAG_W];
    assign line_addr = {data_address[31:4], 4'b0000};
    assign cur_word  = blocks[idx][{word_sel, 5'b00000} +: 32];
    assign request   = read | write;
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign write_hit = (state == IDLE) && write && hit;
    assign line_done = (state == FILL_HIGH) && main_mem_ready;

    always_comb begin
        memoryReady = (state == IDLE) && (!request || hit);
        read_data   = '0;
        if ((state == IDLE) && read && hit)
            read_data = cur_word;
    end

    // Line storage carries no reset; valid bits alone decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (line_done) begin
                blocks[idx] <= load_block;
                tags[idx]   <= tag;
            end else if (write_hit) begin
                blocks[idx][{word_sel, 5'b00000} +: 32] <= write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            valid           <= '0;
            dirty           <= '0;
            evict           <= 1'b0;
            load            <= 1'b0;
            wait_access     <= 1'b0;
            load_address    <= '0;
            evicted_address <= '0;
            evicted_block   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_hit)
                        dirty[idx] <= 1'b1;
                    if (request && !hit && main_mem_ready) begin
                        wait_access <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            evict           <= 1'b1;
                            evicted_block   <= blocks[idx];
                            evicted_address <= {tags[idx], idx, 4'b0000};
`ifdef CACHE_WB_COMBINED_ACCESS_EN
                            load            <= 1'b1;
                            load_address    <= line_addr;
                            state           <= FILL_LOW;
`else
                            state           <= WB_LOW;
`endif
                        end else begin
                            load         <= 1'b1;
                            load_address <= line_addr;
                            state        <= FILL_LOW;
                        end
                    end
                end
                WB_LOW: begin
                    wait_access <= 1'b0;
                    if (!main_mem_ready)
                        state <= WB_HIGH;
                end
                WB_HIGH: begin
                    // Memory is ready again, so the refill can start on this same edge.
                    if (main_mem_ready) begin
                        dirty[idx]      <= 1'b0;
                        evict           <= 1'b0;
                        evicted_block   <= '0;
                        evicted_address <= '0;
                        load            <= 1'b1;
                        load_address    <= line_addr;
                        wait_access     <= 1'b1;
                        state           <= FILL_LOW;
                    end
                end
                FILL_LOW: begin
                    wait_access <= 1'b0;
                    if (!main_mem_ready)
                        state <= FILL_HIGH;
                end
                FILL_HIGH: begin
                    if (main_mem_ready) begin
                        valid[idx]      <= 1'b1;
                        dirty[idx]      <= 1'b0;
                        evict           <= 1'b0;
                        load            <= 1'b0;
                        load_address    <= '0;
                        evicted_block   <= '0;
                        evicted_address <= '0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_wb.sv
// Directed bench for cache_wb with a behavioural single-port memory responder.
module tb_cache_wb;

    logic         clk = 1'b0;
    logic         reset;
    logic         read;
    logic         write;
    logic         main_mem_ready;
    logic [31:0]  data_address;
    logic [31:0]  write_data;
    logic [127:0] load_block;
    logic [31:0]  load_address;
    logic [31:0]  read_data;
    logic [127:0] evicted_block;
    logic [31:0]  evicted_address;
    logic         evict;
    logic         load;
    logic         memoryReady;
    logic         wait_access;

    cache_wb #(.NUM_LINES(16)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .main_mem_ready(main_mem_ready), .data_address(data_address),
        .write_data(write_data), .load_block(load_block),
        .load_address(load_address), .read_data(read_data),
        .evicted_block(evicted_block), .evicted_address(evicted_address),
        .evict(evict), .load(load), .memoryReady(memoryReady),
        .wait_access(wait_access)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [127:0] mem [logic [31:0]];

    int           wa_cnt, ev_cnt, ld_cnt, both_cnt;
    logic [31:0]  ev_addr, ld_addr;
    logic [127:0] ev_blk;

    // Activity monitor
    initial begin
        forever begin
            @(posedge clk); #1;
            if (wait_access) wa_cnt++;
            if (evict) begin ev_cnt++; ev_addr = evicted_address; ev_blk = evicted_block; end
            if (load) begin ld_cnt++; ld_addr = load_address; end
            if (evict && load) both_cnt++;
        end
    end

    // Memory: drops ready after a start pulse, completes two cycles later
    initial begin
        logic         t_ev, t_ld;
        logic [31:0]  t_ev_addr, t_ld_addr;
        logic [127:0] t_ev_blk;
        main_mem_ready = 1'b1;
        load_block     = '0;
        forever begin
            @(posedge clk); #1;
            if (wait_access) begin
                t_ev = evict; t_ev_addr = evicted_address; t_ev_blk = evicted_block;
                t_ld = load;  t_ld_addr = load_address;
                main_mem_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                if (t_ev) mem[t_ev_addr] = t_ev_blk;
                if (t_ld) load_block = mem.exists(t_ld_addr) ? mem[t_ld_addr] : 128'h0;
                main_mem_ready = 1'b1;
            end
        end
    end

    task automatic clear_counters();
        wa_cnt = 0; ev_cnt = 0; ld_cnt = 0; both_cnt = 0;
        ev_addr = '0; ld_addr = '0; ev_blk = '0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output int waited, output logic ok);
        @(negedge clk);
        read = rd; write = wr; data_address = addr; write_data = wd;
        #1;
        waited = 0; ok = 1'b1;
        while (!memoryReady) begin
            if (waited >= 100) begin ok = 1'b0; break; end
            @(negedge clk); #1;
            waited++;
        end
        rdata = read_data;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (evict !== 1'b0) begin fails++; $display("FAIL reset_evict: got %b want 0", evict); end
        checks++; if (load !== 1'b0) begin fails++; $display("FAIL reset_load: got %b want 0", load); end
        checks++; if (wait_access !== 1'b0) begin fails++; $display("FAIL reset_wait: got %b want 0", wait_access); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (memoryReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", memoryReady); end
        checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", read_data); end
        checks++; if (load_address !== 32'h0) begin fails++; $display("FAIL reset_ldaddr: got %h want 0", load_address); end
    endtask

    task automatic test_fill();
        logic [31:0] rd; int w; logic ok;
        clear_counters();
        access(1'b1, 1'b0, 32'h10, 32'h0, rd, w, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL fill_timeout: got %b want 1", ok); end
        checks++; if (rd !== 32'h1) begin fails++; $display("FAIL fill_rdata: got %h want 00000001", rd); end
        checks++; if (wa_cnt !== 1) begin fails++; $display("FAIL fill_pulses: got %0d want 1", wa_cnt); end
        checks++; if (ld_addr !== 32'h10) begin fails++; $display("FAIL fill_ldaddr: got %h want 00000010", ld_addr); end
        checks++; if (ev_cnt !== 0) begin fails++; $display("FAIL fill_evict: got %0d cycles want 0", ev_cnt); end
        clear_counters();
        access(1'b1, 1'b0, 32'h10, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'h1) begin fails++; $display("FAIL rehit_rdata: got %h want 00000001", rd); end
        checks++; if (wa_cnt !== 0 || w !== 0) begin fails++; $display("FAIL rehit_mem: got %0d pulses %0d waits want 0 0", wa_cnt, w); end
        access(1'b1, 1'b0, 32'h1C, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'h4) begin fails++; $display("FAIL hit_word3: got %h want 00000004", rd); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int w; logic ok;
        clear_counters();
        access(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, rd, w, ok);
        checks++; if (w !== 0) begin fails++; $display("FAIL wr_hit_wait: got %0d want 0", w); end
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL wr_only_rdata: got %h want 0", rd); end
        access(1'b1, 1'b0, 32'h14, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_readback: got %h want deadbeef", rd); end
        access(1'b1, 1'b1, 32'h18, 32'hCAFEF00D, rd, w, ok);
        checks++; if (rd !== 32'h3) begin fails++; $display("FAIL rw_preword: got %h want 00000003", rd); end
        access(1'b1, 1'b0, 32'h18, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL rw_written: got %h want cafef00d", rd); end
        checks++; if (wa_cnt !== 0) begin fails++; $display("FAIL wr_hit_mem: got %0d pulses want 0", wa_cnt); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd; int w; logic ok;
        clear_counters();
        access(1'b1, 1'b0, 32'h110, 32'h0, rd, w, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL evict_timeout: got %b want 1", ok); end
        checks++; if (rd !== 32'h5) begin fails++; $display("FAIL evict_rdata: got %h want 00000005", rd); end
        checks++; if (ev_addr !== 32'h10) begin fails++; $display("FAIL evict_addr: got %h want 00000010", ev_addr); end
        checks++; if (ev_blk !== {32'h4, 32'hCAFEF00D, 32'hDEADBEEF, 32'h1}) begin fails++; $display("FAIL evict_block: got %h", ev_blk); end
        checks++; if (ld_addr !== 32'h110) begin fails++; $display("FAIL evict_ldaddr: got %h want 00000110", ld_addr); end
        checks++; if (mem[32'h10] !== {32'h4, 32'hCAFEF00D, 32'hDEADBEEF, 32'h1}) begin fails++; $display("FAIL evict_memory: got %h", mem[32'h10]); end
`ifdef CACHE_WB_COMBINED_ACCESS_EN
        checks++; if (wa_cnt !== 1) begin fails++; $display("FAIL evict_pulses: got %0d want 1", wa_cnt); end
        checks++; if (both_cnt == 0) begin fails++; $display("FAIL evict_combined: got %0d overlap cycles want >0", both_cnt); end
`else
        checks++; if (wa_cnt !== 2) begin fails++; $display("FAIL evict_pulses: got %0d want 2", wa_cnt); end
        checks++; if (both_cnt !== 0) begin fails++; $display("FAIL evict_separate: got %0d overlap cycles want 0", both_cnt); end
`endif
        checks++; if (evicted_address !== 32'h0 || evicted_block !== 128'h0 || load_address !== 32'h0)
            begin fails++; $display("FAIL idle_outputs: got %h %h %h want zeros", evicted_address, evicted_block, load_address); end
    endtask

    task automatic test_clean_conflict();
        logic [31:0] rd; int w; logic ok;
        clear_counters();
        access(1'b1, 1'b0, 32'h210, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'h9) begin fails++; $display("FAIL clean_rdata: got %h want 00000009", rd); end
        checks++; if (ev_cnt !== 0) begin fails++; $display("FAIL clean_evict: got %0d cycles want 0", ev_cnt); end
        checks++; if (wa_cnt !== 1) begin fails++; $display("FAIL clean_pulses: got %0d want 1", wa_cnt); end
        checks++; if (ld_addr !== 32'h210) begin fails++; $display("FAIL clean_ldaddr: got %h want 00000210", ld_addr); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; int w; logic ok;
        clear_counters();
        access(1'b0, 1'b1, 32'h34, 32'h12345678, rd, w, ok);
        checks++; if (wa_cnt !== 1 || ev_cnt !== 0) begin fails++; $display("FAIL wmiss_mem: got %0d pulses %0d evict want 1 0", wa_cnt, ev_cnt); end
        access(1'b1, 1'b0, 32'h34, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'h12345678) begin fails++; $display("FAIL wmiss_word: got %h want 12345678", rd); end
        access(1'b1, 1'b0, 32'h3C, 32'h0, rd, w, ok);
        checks++; if (rd !== 32'h34) begin fails++; $display("FAIL wmiss_fillword: got %h want 00000034", rd); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; int w; logic ok; int n;
        @(negedge clk);
        read = 1'b1; data_address = 32'h10;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!load && n < 20);
        checks++; if (load !== 1'b1) begin fails++; $display("FAIL rstfill_start: got %b want 1", load); end
        reset = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        checks++; if (evict !== 1'b0 || load !== 1'b0 || wait_access !== 1'b0)
            begin fails++; $display("FAIL rstfill_outputs: got %b%b%b want 000", evict, load, wait_access); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (memoryReady !== 1'b1) begin fails++; $display("FAIL rstfill_ready: got %b want 1", memoryReady); end
        clear_counters();
        access(1'b1, 1'b0, 32'h10, 32'h0, rd, w, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL rstfill_timeout: got %b want 1", ok); end
        checks++; if (wa_cnt !== 1 || ev_cnt !== 0) begin fails++; $display("FAIL rstfill_remiss: got %0d pulses %0d evict want 1 0", wa_cnt, ev_cnt); end
        checks++; if (rd !== 32'h1) begin fails++; $display("FAIL rstfill_rdata: got %h want 00000001", rd); end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        data_address = '0; write_data = '0;
        mem[32'h10]  = {32'h4, 32'h3, 32'h2, 32'h1};
        mem[32'h110] = {32'h8, 32'h7, 32'h6, 32'h5};
        mem[32'h210] = {32'hC, 32'hB, 32'hA, 32'h9};
        mem[32'h30]  = {32'h34, 32'h33, 32'h32, 32'h31};
        clear_counters();
        test_reset();
        test_fill();
        test_write_hit();
        test_dirty_evict();
        test_clean_conflict();
        test_write_miss();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
